// File: rtl/control_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding, opcode constants, IR field
// positions and instruction-class helpers used by the control sequencer.
package cpu_defs;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        CLS_NOP    = 2'd0,
        CLS_BINARY = 2'd1,
        CLS_UNARY  = 2'd2,
        CLS_HALT   = 2'd3
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OP_W      = 5;
    localparam int REG_W     = 4;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    // Anything not recognised executes as a nop.
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_MUL, OP_DIV: cls = CLS_BINARY;
            OP_NEG, OP_NOT:                  cls = CLS_UNARY;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    function automatic logic is_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Strobe bundle between the control sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
    parameter int NREGS = 16
);
    logic [31:0]      ir;
    logic             mem_ready;
    logic [NREGS-1:0] rin;
    logic [NREGS-1:0] rout;
    logic             pc_out;
    logic             pc_in;
    logic             inc_pc;
    logic             mar_in;
    logic             mdr_read;
    logic             mdr_in;
    logic             mdr_out;
    logic             ir_in;
    logic             y_in;
    logic             zlo_in;
    logic             zhi_in;
    logic             zlo_out;
    logic             zhi_out;
    logic             lo_in;
    logic             hi_in;
    logic [4:0]       alu_op;
    logic             run;
    logic             fault;

    modport master (
        input  ir, mem_ready,
        output rin, rout, pc_out, pc_in, inc_pc, mar_in, mdr_read, mdr_in,
               mdr_out, ir_in, y_in, zlo_in, zhi_in, zlo_out, zhi_out,
               lo_in, hi_in, alu_op, run, fault
    );

    modport slave (
        output ir, mem_ready,
        input  rin, rout, pc_out, pc_in, inc_pc, mar_in, mdr_read, mdr_in,
               mdr_out, ir_in, y_in, zlo_in, zhi_in, zlo_out, zhi_out,
               lo_in, hi_in, alu_op, run, fault
    );
endinterface

// File: rtl/control_sequencer_reg_decode.sv
// Register-field to one-hot decoder; field values at or above NREGS select nothing.
module reg_decode4to16 #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       field,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // Bit i matches field == i only for i < 16, so wide vectors never alias.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (en && (i < 16) && ({28'd0, field} == 32'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch with memory-ready handshake and timeout, then
// execute of register-to-register ALU ops, nop and halt.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int NREGS       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    control_sequencer_if.master   bus
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s, wait_inc_s;
    logic             fault_r, fault_s;

    logic [4:0]       opcode_s;
    logic [3:0]       ra_s, rb_s, rc_s, rout_sel_s;
    op_class_t        class_s;
    logic             wide_s;

    logic             rin_en_s, rout_en_s;
    logic [NREGS-1:0] rin_s, rout_s;
    logic             pc_out_s, pc_in_s, inc_pc_s, mar_in_s;
    logic             mdr_read_s, mdr_in_s, mdr_out_s, ir_in_s, y_in_s;
    logic             zlo_in_s, zhi_in_s, zlo_out_s, zhi_out_s, lo_in_s, hi_in_s;
    logic [4:0]       alu_op_s;

    assign opcode_s   = bus.ir[IR_OP_LSB +: OP_W];
    assign ra_s       = bus.ir[IR_RA_LSB +: REG_W];
    assign rb_s       = bus.ir[IR_RB_LSB +: REG_W];
    assign rc_s       = bus.ir[IR_RC_LSB +: REG_W];
    assign class_s    = classify(opcode_s);
    assign wide_s     = is_wide(opcode_s);
    assign wait_inc_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // State, wait counter and sticky fault; reset wins from every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RST;
            wait_cnt_r <= '0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            fault_r    <= fault_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        fault_s    = fault_r;
        case (state_r)
            ST_RST: begin
                state_s    = ST_T0;
                wait_cnt_s = '0;
            end
            ST_T0: begin
                state_s    = ST_T1;
                wait_cnt_s = '0;
            end
            ST_T1: begin
                if (bus.mem_ready) begin
                    state_s    = ST_T2;
                    wait_cnt_s = '0;
                end else if (wait_inc_s == CNT_W'(MEM_TIMEOUT)) begin
                    state_s    = ST_HALT;
                    wait_cnt_s = wait_inc_s;
                    fault_s    = 1'b1;
                end else begin
                    wait_cnt_s = wait_inc_s;
                end
            end
            ST_T2: begin
                case (class_s)
                    CLS_BINARY: state_s = ST_T3;
                    CLS_UNARY:  state_s = ST_T4;
                    CLS_HALT:   state_s = ST_HALT;
                    default:    state_s = ST_T0;
                endcase
            end
            ST_T3:   state_s = ST_T4;
            ST_T4:   state_s = ST_T5;
            ST_T5:   state_s = wide_s ? ST_T6 : ST_T0;
            ST_T6:   state_s = ST_T0;
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_RST;
        endcase
    end

    // Moore strobe decode; mdr_in is the lone pass-through of mem_ready.
    always_comb begin
        rin_en_s   = 1'b0;
        rout_en_s  = 1'b0;
        rout_sel_s = rb_s;
        pc_out_s   = 1'b0;
        pc_in_s    = 1'b0;
        inc_pc_s   = 1'b0;
        mar_in_s   = 1'b0;
        mdr_read_s = 1'b0;
        mdr_in_s   = 1'b0;
        mdr_out_s  = 1'b0;
        ir_in_s    = 1'b0;
        y_in_s     = 1'b0;
        zlo_in_s   = 1'b0;
        zhi_in_s   = 1'b0;
        zlo_out_s  = 1'b0;
        zhi_out_s  = 1'b0;
        lo_in_s    = 1'b0;
        hi_in_s    = 1'b0;
        alu_op_s   = 5'd0;
        case (state_r)
            ST_T0: begin
                pc_out_s = 1'b1;
                mar_in_s = 1'b1;
                inc_pc_s = 1'b1;
                zlo_in_s = 1'b1;
            end
            ST_T1: begin
                zlo_out_s  = 1'b1;
                pc_in_s    = 1'b1;
                mdr_read_s = 1'b1;
                mdr_in_s   = bus.mem_ready;
            end
            ST_T2: begin
                mdr_out_s = 1'b1;
                ir_in_s   = 1'b1;
            end
            ST_T3: begin
                rout_en_s  = 1'b1;
                rout_sel_s = rb_s;
                y_in_s     = 1'b1;
            end
            ST_T4: begin
                rout_en_s  = 1'b1;
                rout_sel_s = (class_s == CLS_UNARY) ? rb_s : rc_s;
                alu_op_s   = opcode_s;
                zlo_in_s   = 1'b1;
                zhi_in_s   = wide_s;
            end
            ST_T5: begin
                zlo_out_s = 1'b1;
                if (wide_s) begin
                    lo_in_s = 1'b1;
                end else begin
                    rin_en_s = 1'b1;
                end
            end
            ST_T6: begin
                zhi_out_s = 1'b1;
                hi_in_s   = 1'b1;
            end
            default: begin
                rin_en_s  = 1'b0;
                rout_en_s = 1'b0;
            end
        endcase
    end

    reg_decode4to16 #(.NREGS(NREGS)) u_rin_dec (
        .field  (ra_s),
        .en     (rin_en_s),
        .onehot (rin_s)
    );

    reg_decode4to16 #(.NREGS(NREGS)) u_rout_dec (
        .field  (rout_sel_s),
        .en     (rout_en_s),
        .onehot (rout_s)
    );

    assign bus.rin      = rin_s;
    assign bus.rout     = rout_s;
    assign bus.pc_out   = pc_out_s;
    assign bus.pc_in    = pc_in_s;
    assign bus.inc_pc   = inc_pc_s;
    assign bus.mar_in   = mar_in_s;
    assign bus.mdr_read = mdr_read_s;
    assign bus.mdr_in   = mdr_in_s;
    assign bus.mdr_out  = mdr_out_s;
    assign bus.ir_in    = ir_in_s;
    assign bus.y_in     = y_in_s;
    assign bus.zlo_in   = zlo_in_s;
    assign bus.zhi_in   = zhi_in_s;
    assign bus.zlo_out  = zlo_out_s;
    assign bus.zhi_out  = zhi_out_s;
    assign bus.lo_in    = lo_in_s;
    assign bus.hi_in    = hi_in_s;
    assign bus.alu_op   = alu_op_s;
    assign bus.run      = (state_r != ST_RST) && (state_r != ST_HALT);
    assign bus.fault    = fault_r;

endmodule
